ibex_decoder_stream_wrap: RTL and testbench

Buffered, handshaked test harness around `ibex_decoder`. It accepts a stream of 32-bit instruction words, queues them in a parametrised FIFO, and decodes one word per cycle. Each result (instruction, opcode, illegal flag) is registered and handed out on a valid/ready interface. It optionally keeps saturating counters of decoded and illegal instructions. It is the top level for stream-driven decoder coverage runs, replacing single-word combinational wrapping.

---
 rtl/ibex_decoder_stream_wrap.sv | 209 ++++++++++++++++++++
 tb/tb_ibex_decoder_stream_wrap.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_decoder_stream_wrap.sv
// Stream harness around ibex_decoder: input FIFO, registered valid/ready result stage and
// optional saturating decode statistics (compiled in with IBEX_DEC_STREAM_CNT_EN).

// Stand-in ibex_decoder exposing only the illegal-instruction flag used by the harness.
module ibex_decoder #(
   parameter bit BranchTargetALU = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        branch_taken_i,
   input  logic        instr_first_cycle_i,
   input  logic        illegal_c_insn_i,
   input  logic [31:0] instr_rdata_i,
   input  logic [31:0] instr_rdata_alu_i,
   output logic        illegal_insn_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       base_illegal;
   logic       unused_ctrl;

   // Opcode and funct3 come from the main copy, funct7 from the ALU copy (as in the core).
   assign opcode = instr_rdata_i[6:0];
   assign funct3 = instr_rdata_i[14:12];
   assign funct7 = instr_rdata_alu_i[31:25];

   assign unused_ctrl = ^{clk_i, rst_ni, branch_taken_i, instr_first_cycle_i, BranchTargetALU,
                          instr_rdata_i[31:15], instr_rdata_i[11:7], instr_rdata_alu_i[24:0]};

   always_comb begin
      base_illegal = 1'b1;
      case (opcode)
         7'h37, 7'h17, 7'h6f: base_illegal = 1'b0;
         7'h67: base_illegal = (funct3 != 3'd0);
         7'h63: base_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
         7'h03: base_illegal = (funct3 == 3'd3) || (funct3 >= 3'd6);
         7'h23: base_illegal = (funct3 > 3'd2);
         7'h13: begin
            case (funct3)
               3'd1:    base_illegal = (funct7 != 7'h00);
               3'd5:    base_illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
               default: base_illegal = 1'b0;
            endcase
         end
         7'h33: begin
            if ((funct7 == 7'h00) || (funct7 == 7'h01)) begin
               base_illegal = 1'b0;
            end else if (funct7 == 7'h20) begin
               base_illegal = !((funct3 == 3'd0) || (funct3 == 3'd5));
            end else begin
               base_illegal = 1'b1;
            end
         end
         7'h0f: base_illegal = (funct3 > 3'd1);
         7'h73: base_illegal = (funct3 == 3'd4);
         default: base_illegal = 1'b1;
      endcase
   end

   assign illegal_insn_o = base_illegal | illegal_c_insn_i;

endmodule

module ibex_decoder_stream_wrap #(
   parameter int unsigned Depth           = 4,
   parameter int unsigned CntWidth        = 16,
   parameter bit          BranchTargetALU = 1'b1,
   localparam int unsigned LvlW           = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                insn_valid_i,
   output logic                insn_ready_o,
   input  logic [31:0]         insn_i,
   input  logic                flush_i,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [31:0]         res_insn_o,
   output logic [6:0]          res_opcode_o,
   output logic                res_illegal_o,
   output logic [LvlW-1:0]     fifo_level_o,
   output logic [CntWidth-1:0] cnt_total_o,
   output logic [CntWidth-1:0] cnt_illegal_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [LvlW-1:0] FullLvl = LvlW'(Depth);

   logic [31:0]     mem [Depth];
   logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [LvlW-1:0] level_reg, level_next;
   logic            res_valid_reg, res_valid_next;
   logic [31:0]     res_insn_reg;
   logic            res_illegal_reg;
   logic [31:0]     head_word;
   logic            dec_illegal;
   logic            push, pop;

   assign insn_ready_o = (level_reg != FullLvl);
   assign push         = insn_valid_i && insn_ready_o && !flush_i;
   // No bypass: a word must sit at the FIFO head for a cycle before it can load.
   assign pop          = (level_reg != '0) && (!res_valid_reg || res_ready_i) && !flush_i;
   assign head_word    = mem[rd_ptr_reg];

   ibex_decoder #(
      .BranchTargetALU (BranchTargetALU)
   ) u_decoder (
      .clk_i               (clk_i),
      .rst_ni              (~rst_i),
      .branch_taken_i      (1'b1),
      .instr_first_cycle_i (1'b1),
      .illegal_c_insn_i    (1'b0),
      .instr_rdata_i       (head_word),
      .instr_rdata_alu_i   (head_word),
      .illegal_insn_o      (dec_illegal)
   );

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_reg] <= insn_i;
      end
   end

   always_comb begin
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      level_next     = level_reg;
      res_valid_next = res_valid_reg;
      if (flush_i) begin
         wr_ptr_next    = '0;
         rd_ptr_next    = '0;
         level_next     = '0;
         res_valid_next = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
         endcase
         if (pop) begin
            res_valid_next = 1'b1;
         end else if (res_ready_i) begin
            res_valid_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         level_reg       <= '0;
         res_valid_reg   <= 1'b0;
         res_insn_reg    <= '0;
         res_illegal_reg <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         level_reg     <= level_next;
         res_valid_reg <= res_valid_next;
         if (pop) begin
            res_insn_reg    <= head_word;
            res_illegal_reg <= dec_illegal;
         end
      end
   end

   assign res_valid_o   = res_valid_reg;
   assign res_insn_o    = res_insn_reg;
   assign res_opcode_o  = res_insn_reg[6:0];
   assign res_illegal_o = res_illegal_reg;
   assign fifo_level_o  = level_reg;

`ifdef IBEX_DEC_STREAM_CNT_EN
   logic [CntWidth-1:0] cnt_total_reg;
   logic [CntWidth-1:0] cnt_illegal_reg;

   // Saturate at all-ones so long coverage runs never wrap back to small counts.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_total_reg   <= '0;
         cnt_illegal_reg <= '0;
      end else if (pop) begin
         if (cnt_total_reg != '1) begin
            cnt_total_reg <= cnt_total_reg + 1'b1;
         end
         if (dec_illegal && (cnt_illegal_reg != '1)) begin
            cnt_illegal_reg <= cnt_illegal_reg + 1'b1;
         end
      end
   end

   assign cnt_total_o   = cnt_total_reg;
   assign cnt_illegal_o = cnt_illegal_reg;
`else
   assign cnt_total_o   = '0;
   assign cnt_illegal_o = '0;
`endif

endmodule

// File: tb/tb_ibex_decoder_stream_wrap.sv
// Randomised and directed bench for ibex_decoder_stream_wrap against a queue-based model
// of the stream harness and a table-style RV32 legality reference.
`timescale 1ns/1ps
module tb_ibex_decoder_stream_wrap;

   localparam int DEPTH   = 4;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          insn_valid = 1'b0;
   logic          insn_ready;
   logic [31:0]   insn = '0;
   logic          flush = 1'b0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [31:0]   res_insn;
   logic [6:0]    res_opcode;
   logic          res_illegal;
   logic [2:0]    fifo_level;
   logic [CW-1:0] cnt_total;
   logic [CW-1:0] cnt_illegal;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [31:0] q[$];
   bit          m_valid;
   logic [31:0] m_insn;
   bit          m_ill;
   int          m_tot;
   int          m_illc;

   ibex_decoder_stream_wrap #(
      .Depth           (DEPTH),
      .CntWidth        (CW),
      .BranchTargetALU (1'b1)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .insn_valid_i  (insn_valid),
      .insn_ready_o  (insn_ready),
      .insn_i        (insn),
      .flush_i       (flush),
      .res_valid_o   (res_valid),
      .res_ready_i   (res_ready),
      .res_insn_o    (res_insn),
      .res_opcode_o  (res_opcode),
      .res_illegal_o (res_illegal),
      .fifo_level_o  (fifo_level),
      .cnt_total_o   (cnt_total),
      .cnt_illegal_o (cnt_illegal)
   );

   always #5 clk = ~clk;

   function automatic int exp_cnt(input int c);
`ifdef IBEX_DEC_STREAM_CNT_EN
      return c;
`else
      return 0;
`endif
   endfunction

   // RV32IM legality as a list of accepted opcode/funct combinations.
   function automatic bit ref_illegal(input logic [31:0] w);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      opc = w[6:0];
      f3  = w[14:12];
      f7  = w[31:25];
      if (opc inside {7'h37, 7'h17, 7'h6f}) return 1'b0;
      if (opc == 7'h67) return f3 != 3'd0;
      if (opc == 7'h63) return f3 inside {3'd2, 3'd3};
      if (opc == 7'h03) return f3 inside {3'd3, 3'd6, 3'd7};
      if (opc == 7'h23) return f3 > 3'd2;
      if (opc == 7'h13) begin
         if (f3 == 3'd1) return f7 != 7'h00;
         if (f3 == 3'd5) return !(f7 inside {7'h00, 7'h20});
         return 1'b0;
      end
      if (opc == 7'h33) begin
         if (f7 inside {7'h00, 7'h01}) return 1'b0;
         if (f7 == 7'h20) return !(f3 inside {3'd0, 3'd5});
         return 1'b1;
      end
      if (opc == 7'h0f) return f3 > 3'd1;
      if (opc == 7'h73) return f3 == 3'd4;
      return 1'b1;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 12))
         0:  w[6:0] = 7'h37;
         1:  w[6:0] = 7'h17;
         2:  w[6:0] = 7'h6f;
         3:  w[6:0] = 7'h67;
         4:  w[6:0] = 7'h63;
         5:  w[6:0] = 7'h03;
         6:  w[6:0] = 7'h23;
         7:  w[6:0] = 7'h13;
         8:  w[6:0] = 7'h33;
         9:  w[6:0] = 7'h0f;
         10: w[6:0] = 7'h73;
         11: w[6:0] = 7'h00;
         default: ;
      endcase
      case ($urandom_range(0, 3))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h01;
         2: w[31:25] = 7'h20;
         default: ;
      endcase
      return w;
   endfunction

   task automatic reset_model();
      q.delete();
      m_valid = 1'b0;
      m_insn  = '0;
      m_ill   = 1'b0;
      m_tot   = 0;
      m_illc  = 0;
   endtask

   // One clock edge: apply the stream rules to the model, then settle past the edge.
   task automatic tick();
      bit push, pop;
      push = insn_valid && (q.size() < DEPTH) && !flush;
      pop  = (q.size() > 0) && (!m_valid || res_ready) && !flush;
      @(posedge clk);
      if (flush) begin
         q.delete();
         m_valid = 1'b0;
      end else begin
         if (pop) begin
            m_insn  = q.pop_front();
            m_ill   = ref_illegal(m_insn);
            m_valid = 1'b1;
            if (m_tot < CNT_MAX) m_tot++;
            if (m_ill && m_illc < CNT_MAX) m_illc++;
         end else if (res_ready) begin
            m_valid = 1'b0;
         end
         if (push) q.push_back(insn);
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (insn_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", insn_ready); else n_pass++;
      n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", res_valid); else n_pass++;
      n_checks++; if (res_insn !== 32'h0) $display("FAIL reset_insn: got %h want 0", res_insn); else n_pass++;
      n_checks++; if (res_opcode !== 7'h0) $display("FAIL reset_opcode: got %h want 0", res_opcode); else n_pass++;
      n_checks++; if (res_illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", res_illegal); else n_pass++;
      n_checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else n_pass++;
      n_checks++; if (cnt_total !== 4'd0 || cnt_illegal !== 4'd0)
         $display("FAIL reset_counters: got %0d/%0d want 0/0", cnt_total, cnt_illegal); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      $display("reset: released");
   endtask

   task automatic test_single_word();
      res_ready  = 1'b1;
      insn       = 32'h0000_0013;
      insn_valid = 1'b1;
      n_checks++; if (insn_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", insn_ready); else n_pass++;
      tick();
      insn_valid = 1'b0;
      n_checks++; if (res_valid !== 1'b0 || fifo_level !== 3'd1)
         $display("FAIL single_stage1: valid %b level %0d want 0 and 1", res_valid, fifo_level); else n_pass++;
      tick();
      n_checks++; if (res_valid !== 1'b1 || res_insn !== 32'h0000_0013)
         $display("FAIL single_result: valid %b insn %h want 1 00000013", res_valid, res_insn); else n_pass++;
      n_checks++; if (res_opcode !== 7'h13 || res_illegal !== 1'b0)
         $display("FAIL single_decode: opcode %h illegal %b want 13 0", res_opcode, res_illegal); else n_pass++;
      n_checks++; if (int'(cnt_total) != exp_cnt(1))
         $display("FAIL single_cnt_total: got %0d want %0d", cnt_total, exp_cnt(1)); else n_pass++;
      $display("single_word: insn %h illegal %b total %0d", res_insn, res_illegal, cnt_total);
      tick();
   endtask

   task automatic test_illegal();
      insn       = 32'h0000_0000;
      insn_valid = 1'b1;
      tick();
      insn_valid = 1'b0;
      tick();
      n_checks++; if (res_valid !== 1'b1 || res_illegal !== 1'b1)
         $display("FAIL illegal_flag: valid %b illegal %b want 1 1", res_valid, res_illegal); else n_pass++;
      n_checks++; if (int'(cnt_illegal) != exp_cnt(1) || int'(cnt_total) != exp_cnt(2))
         $display("FAIL illegal_counters: got %0d/%0d want %0d/%0d", cnt_illegal, cnt_total, exp_cnt(1), exp_cnt(2));
      else n_pass++;
      $display("illegal: insn %h illegal %b cnt_illegal %0d", res_insn, res_illegal, cnt_illegal);
      tick();
   endtask

   task automatic test_backpressure();
      logic [31:0] w [6];
      int accepted = 0;
      for (int k = 0; k < 6; k++) w[k] = 32'h0000_0013 | (k << 20);
      res_ready  = 1'b0;
      insn_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         insn = w[accepted];
         if (insn_ready) accepted++;
         tick();
      end
      insn_valid = 1'b0;
      n_checks++; if (accepted != 5) $display("FAIL bp_accepts: got %0d want 5", accepted); else n_pass++;
      n_checks++; if (insn_ready !== 1'b0 || fifo_level !== 3'd4)
         $display("FAIL bp_full: ready %b level %0d want 0 4", insn_ready, fifo_level); else n_pass++;
      res_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (res_valid !== 1'b1 || res_insn !== w[k])
            $display("FAIL bp_order%0d: valid %b insn %h want 1 %h", k, res_valid, res_insn, w[k]);
         else n_pass++;
         $display("backpressure: out %0d insn %h", k, res_insn);
         tick();
      end
      n_checks++; if (res_valid !== 1'b0) $display("FAIL bp_drained: valid %b want 0", res_valid); else n_pass++;
   endtask

   task automatic test_flush();
      logic [CW-1:0] tot_before, ill_before;
      res_ready  = 1'b0;
      insn_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         insn = rand_word();
         tick();
      end
      tot_before = cnt_total;
      ill_before = cnt_illegal;
      n_checks++; if (fifo_level !== 3'd4 || res_valid !== 1'b1)
         $display("FAIL flush_setup: level %0d valid %b want 4 1", fifo_level, res_valid); else n_pass++;
      flush = 1'b1;
      insn  = 32'h0000_0013;
      tick();
      flush      = 1'b0;
      insn_valid = 1'b0;
      n_checks++; if (fifo_level !== 3'd0 || res_valid !== 1'b0 || insn_ready !== 1'b1)
         $display("FAIL flush_clear: level %0d valid %b ready %b want 0 0 1", fifo_level, res_valid, insn_ready);
      else n_pass++;
      n_checks++; if (cnt_total !== tot_before || cnt_illegal !== ill_before)
         $display("FAIL flush_counters: got %0d/%0d want %0d/%0d", cnt_total, cnt_illegal, tot_before, ill_before);
      else n_pass++;
      tick();
      n_checks++; if (fifo_level !== 3'd0 || res_valid !== 1'b0)
         $display("FAIL flush_dropped: level %0d valid %b want 0 0", fifo_level, res_valid); else n_pass++;
      $display("flush: level %0d valid %b", fifo_level, res_valid);
   endtask

   task automatic test_random();
      int errs_before;
      for (int c = 0; c < 400; c++) begin
         insn_valid = ($urandom_range(0, 3) != 0);
         res_ready  = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 31) == 0);
         insn       = rand_word();
         errs_before = n_checks - n_pass;
         n_checks++; if (insn_ready !== (q.size() < DEPTH))
            $display("FAIL rnd_ready c%0d: got %b want %b", c, insn_ready, q.size() < DEPTH); else n_pass++;
         tick();
         n_checks++; if (res_valid !== m_valid || int'(fifo_level) != q.size())
            $display("FAIL rnd_state c%0d: valid %b level %0d want %b %0d", c, res_valid, fifo_level, m_valid, q.size());
         else n_pass++;
         if (m_valid) begin
            n_checks++; if (res_insn !== m_insn || res_opcode !== m_insn[6:0] || res_illegal !== m_ill)
               $display("FAIL rnd_result c%0d: insn %h op %h ill %b want %h %h %b",
                        c, res_insn, res_opcode, res_illegal, m_insn, m_insn[6:0], m_ill);
            else n_pass++;
         end
         n_checks++; if (int'(cnt_total) != exp_cnt(m_tot) || int'(cnt_illegal) != exp_cnt(m_illc))
            $display("FAIL rnd_counters c%0d: got %0d/%0d want %0d/%0d",
                     c, cnt_total, cnt_illegal, exp_cnt(m_tot), exp_cnt(m_illc));
         else n_pass++;
         $display("random c%0d: in %b/%h flush %b out %b/%h ill %b lvl %0d errs %0d", c, insn_valid, insn,
                  flush, res_valid, res_insn, res_illegal, fifo_level, (n_checks - n_pass) - errs_before);
      end
      flush      = 1'b0;
      insn_valid = 1'b0;
      res_ready  = 1'b1;
      repeat (DEPTH + 2) tick();
   endtask

   task automatic test_saturation();
      @(negedge clk);
      rst = 1'b1;
      reset_model();
      #1;
      rst = 1'b0;
      res_ready  = 1'b1;
      insn_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         insn = $urandom;
         insn[6:0] = (k % 2 == 0) ? 7'h00 : 7'h7f;
         tick();
      end
      insn_valid = 1'b0;
      repeat (3) tick();
      n_checks++; if (int'(cnt_total) != exp_cnt(CNT_MAX) || int'(cnt_illegal) != exp_cnt(CNT_MAX))
         $display("FAIL sat_counters: got %0d/%0d want %0d/%0d",
                  cnt_total, cnt_illegal, exp_cnt(CNT_MAX), exp_cnt(CNT_MAX));
      else n_pass++;
      $display("saturation: total %0d illegal %0d", cnt_total, cnt_illegal);
   endtask

   task automatic test_async_reset();
      res_ready  = 1'b0;
      insn_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         insn = 32'h0000_0013 | (k << 7);
         tick();
      end
      insn_valid = 1'b0;
      n_checks++; if (fifo_level !== 3'd3 || res_valid !== 1'b1)
         $display("FAIL arst_setup: level %0d valid %b want 3 1", fifo_level, res_valid); else n_pass++;
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (res_valid !== 1'b0 || fifo_level !== 3'd0 || insn_ready !== 1'b1)
         $display("FAIL arst_state: valid %b level %0d ready %b want 0 0 1", res_valid, fifo_level, insn_ready);
      else n_pass++;
      n_checks++; if (res_insn !== 32'h0 || res_opcode !== 7'h0 || res_illegal !== 1'b0 ||
                      cnt_total !== 4'd0 || cnt_illegal !== 4'd0)
         $display("FAIL arst_outputs: insn %h op %h ill %b cnt %0d/%0d want all zero",
                  res_insn, res_opcode, res_illegal, cnt_total, cnt_illegal);
      else n_pass++;
      reset_model();
      @(negedge clk);
      rst        = 1'b0;
      res_ready  = 1'b1;
      insn       = 32'h0010_0093;
      insn_valid = 1'b1;
      tick();
      insn_valid = 1'b0;
      tick();
      n_checks++; if (res_valid !== 1'b1 || res_insn !== 32'h0010_0093 || int'(cnt_total) != exp_cnt(1))
         $display("FAIL arst_resume: valid %b insn %h total %0d want 1 00100093 %0d",
                  res_valid, res_insn, cnt_total, exp_cnt(1));
      else n_pass++;
      $display("async_reset: resumed insn %h", res_insn);
      tick();
   endtask

   initial begin
      test_reset();
      @(posedge clk);
      #1;
      test_single_word();
      test_illegal();
      test_backpressure();
      test_flush();
      test_random();
      test_saturation();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
